ame_max_search: RTL and testbench

AME_MAX_SEARCH -- requirements
Module: ame_max_search

---
 rtl/ame_max_search_pkg.sv | 19 +
 rtl/ame_max_search_if.sv | 35 +++
 rtl/ame_max_tree.sv | 75 +++++++
 rtl/ame_max_search.sv | 124 ++++++++++++
 tb/tb_ame_max_search.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ame_max_search_pkg.sv
// rtl/ame_max_search_pkg.sv - shared constants, state type and index-width helper for the max search
package ame_max_search_pkg;

  localparam int DEF_COMP_DATA_BITS = 64;
  localparam int DEF_COMP_NUM       = 8;
  localparam int DEF_COMP_ROWS      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int row_idx_bits(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/ame_max_search_if.sv
// rtl/ame_max_search_if.sv - control, beat stream and result bundle of the max search
interface ame_max_search_if
  import ame_max_search_pkg::*;
#(
  parameter int COMP_DATA_BITS = DEF_COMP_DATA_BITS,
  parameter int COMP_NUM       = DEF_COMP_NUM,
  parameter int COMP_ROWS      = DEF_COMP_ROWS
) ();

  localparam int COL_IDX_BITS = $clog2(COMP_NUM);
  localparam int ROW_IDX_BITS = row_idx_bits(COMP_ROWS);

  logic                                     comp_init_i;
  logic                                     comp_abs_i;
  logic                                     comp_valid_i;
  logic                                     comp_ready_o;
  logic [COMP_NUM-1:0][COMP_DATA_BITS-1:0]  comp_data_i;
  logic [COMP_NUM-1:0]                      comp_data_mask_i;
  logic                                     comp_busy_o;
  logic                                     comp_done_o;
  logic [COMP_DATA_BITS-1:0]                comp_data_o;
  logic [ROW_IDX_BITS-1:0]                  comp_data_row_o;
  logic [COL_IDX_BITS-1:0]                  comp_data_col_o;

  modport master (
    output comp_init_i, comp_abs_i, comp_valid_i, comp_data_i, comp_data_mask_i,
    input  comp_ready_o, comp_busy_o, comp_done_o, comp_data_o, comp_data_row_o, comp_data_col_o
  );

  modport slave (
    input  comp_init_i, comp_abs_i, comp_valid_i, comp_data_i, comp_data_mask_i,
    output comp_ready_o, comp_busy_o, comp_done_o, comp_data_o, comp_data_row_o, comp_data_col_o
  );

endinterface

// File: rtl/ame_max_tree.sv
// rtl/ame_max_tree.sv - pipelined pairwise max reduction over NUM unsigned lane keys, one register per level
module ame_max_tree #(
  parameter int KEY_BITS = 64,
  parameter int NUM      = 8,
  parameter int ROW_BITS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid,
  input  logic [NUM-1:0][KEY_BITS-1:0]  in_key,
  input  logic [ROW_BITS-1:0]           in_row,
  output logic                          out_valid,
  output logic [KEY_BITS-1:0]           out_key,
  output logic [$clog2(NUM)-1:0]        out_col,
  output logic [ROW_BITS-1:0]           out_row,
  output logic                          pipe_busy
);

  localparam int COL_BITS = $clog2(NUM);
  localparam int STAGES   = $clog2(NUM);

  // Heap layout: nodes 0..NUM-2 are registered comparators, NUM-1..2*NUM-2 are the lanes in order,
  // so a left child always covers lower lanes than its right sibling.
  logic [KEY_BITS-1:0] node_key [NUM-1];
  logic [COL_BITS-1:0] node_col [NUM-1];
  logic [KEY_BITS-1:0] all_key  [2*NUM-1];
  logic [COL_BITS-1:0] all_col  [2*NUM-1];
  logic [STAGES-1:0]   vld;
  logic [ROW_BITS-1:0] row_sr   [STAGES];

  always_comb begin
    for (int i = 0; i < NUM-1; i++) begin
      all_key[i] = node_key[i];
      all_col[i] = node_col[i];
    end
    for (int j = 0; j < NUM; j++) begin
      all_key[NUM-1+j] = in_key[j];
      all_col[NUM-1+j] = COL_BITS'(j);
    end
  end

  // The right (higher-lane) child wins only on a strictly greater key.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM-1; i++) begin
      if (all_key[2*i+2] > all_key[2*i+1]) begin
        node_key[i] <= all_key[2*i+2];
        node_col[i] <= all_col[2*i+2];
      end else begin
        node_key[i] <= all_key[2*i+1];
        node_col[i] <= all_col[2*i+1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld[k] <= vld[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    row_sr[0] <= in_row;
    for (int k = 1; k < STAGES; k++) row_sr[k] <= row_sr[k-1];
  end

  assign out_valid = vld[STAGES-1];
  assign out_key   = all_key[0];
  assign out_col   = all_col[0];
  assign out_row   = row_sr[STAGES-1];
  assign pipe_busy = |vld;

endmodule

// File: rtl/ame_max_search.sv
// rtl/ame_max_search.sv - finds the maximum (signed or magnitude) lane value and its position over COMP_ROWS beats
module ame_max_search
  import ame_max_search_pkg::*;
#(
  parameter int COMP_DATA_BITS = DEF_COMP_DATA_BITS,
  parameter int COMP_NUM       = DEF_COMP_NUM,
  parameter int COMP_ROWS      = DEF_COMP_ROWS
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ame_max_search_if.slave    bus
);

  localparam int COL_IDX_BITS = $clog2(COMP_NUM);
  localparam int ROW_IDX_BITS = row_idx_bits(COMP_ROWS);
  localparam int TREE_STAGES  = $clog2(COMP_NUM);
  localparam logic [ROW_IDX_BITS-1:0] LAST_ROW = ROW_IDX_BITS'(COMP_ROWS - 1);
  localparam int MSB = COMP_DATA_BITS - 1;

  state_t                                  state, state_nx;
  logic [ROW_IDX_BITS-1:0]                 beat_cnt;
  logic                                    abs_mode;
  logic                                    accept;
  logic [COMP_NUM-1:0][COMP_DATA_BITS-1:0] lane_key;

  logic                      t_valid, t_busy;
  logic [COMP_DATA_BITS-1:0] t_key;
  logic [COL_IDX_BITS-1:0]   t_col;
  logic [ROW_IDX_BITS-1:0]   t_row;

  logic [COMP_DATA_BITS-1:0] best_key;
  logic [COL_IDX_BITS-1:0]   best_col;
  logic [ROW_IDX_BITS-1:0]   best_row;

  logic [COMP_DATA_BITS-1:0] res_data;
  logic [COL_IDX_BITS-1:0]   res_col;
  logic [ROW_IDX_BITS-1:0]   res_row;

  assign accept = (state == ST_RUN) && bus.comp_valid_i;

  // Keys are unsigned so one comparator serves both modes: signed values are mapped to offset
  // binary (MSB flipped), which puts the most negative value at 0, same as a masked lane.
  always_comb begin
    for (int j = 0; j < COMP_NUM; j++) begin
      lane_key[j] = '0;
      if (!bus.comp_data_mask_i[j]) begin
        if (abs_mode)
          lane_key[j] = bus.comp_data_i[j][MSB] ? (COMP_DATA_BITS'(0) - bus.comp_data_i[j])
                                                : bus.comp_data_i[j];
        else
          lane_key[j] = {~bus.comp_data_i[j][MSB], bus.comp_data_i[j][MSB-1:0]};
      end
    end
  end

  ame_max_tree #(
    .KEY_BITS (COMP_DATA_BITS),
    .NUM      (COMP_NUM),
    .ROW_BITS (ROW_IDX_BITS)
  ) u_tree (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (accept),
    .in_key    (lane_key),
    .in_row    (beat_cnt),
    .out_valid (t_valid),
    .out_key   (t_key),
    .out_col   (t_col),
    .out_row   (t_row),
    .pipe_busy (t_busy)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.comp_init_i) state_nx = ST_RUN;
      ST_RUN:   if (accept && beat_cnt == LAST_ROW) state_nx = ST_DRAIN;
      ST_DRAIN: if (!t_busy) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      abs_mode <= 1'b0;
      res_data <= '0;
      res_row  <= '0;
      res_col  <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && bus.comp_init_i) begin
        beat_cnt <= '0;
        abs_mode <= bus.comp_abs_i;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (state == ST_DRAIN && state_nx == ST_DONE) begin
        res_data <= abs_mode ? best_key : {~best_key[MSB], best_key[MSB-1:0]};
        res_row  <= best_row;
        res_col  <= best_col;
      end
    end
  end

  // Beat 0 always seeds the running max; later beats replace it only when strictly greater.
  always_ff @(posedge clk_i) begin
    if (t_valid && (t_row == '0 || t_key > best_key)) begin
      best_key <= t_key;
      best_col <= t_col;
      best_row <= t_row;
    end
  end

  assign bus.comp_ready_o    = (state == ST_RUN);
  assign bus.comp_busy_o     = (state != ST_IDLE);
  assign bus.comp_done_o     = (state == ST_DONE);
  assign bus.comp_data_o     = res_data;
  assign bus.comp_data_row_o = res_row;
  assign bus.comp_data_col_o = res_col;

endmodule

// File: tb/tb_ame_max_search.sv
// tb/tb_ame_max_search.sv - scoreboard bench for ame_max_search with a row-major reference scan
module tb_ame_max_search;

  localparam int W = 64;
  localparam int N = 8;
  localparam int R = 4;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ame_max_search_if #(.COMP_DATA_BITS(W), .COMP_NUM(N), .COMP_ROWS(R)) bus ();

  ame_max_search #(.COMP_DATA_BITS(W), .COMP_NUM(N), .COMP_ROWS(R)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   r;
    logic [2:0]   c;
    int           cy;
  } exp_t;

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  int           dones = 0;
  int           pushed = 0;
  logic [W-1:0] bd [R][N];
  logic [N-1:0] bm [R];
  exp_t         sbq [$];
  exp_t         mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Reference: scan all elements row-major, lane ascending, keeping the first strictly greater key.
  function automatic exp_t model(input bit am);
    exp_t e;
    logic signed [65:0] x, k, bk;
    bk = '0;
    e = '{d: '0, r: '0, c: '0, cy: 0};
    for (int r = 0; r < R; r++) begin
      for (int l = 0; l < N; l++) begin
        x = $signed({{2{bd[r][l][W-1]}}, bd[r][l]});
        k = am ? ((x < 0) ? -x : x) : x;
        if (bm[r][l]) k = am ? 66'sd0 : -66'sd9223372036854775808;
        if ((r == 0 && l == 0) || k > bk) begin
          bk  = k;
          e.d = k[W-1:0];
          e.r = 2'(r);
          e.c = 3'(l);
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.comp_done_o) begin
      dones++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: done pulse at cycle %0d, required none", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("done_data", bus.comp_data_o, mon_e.d);
        chk("done_row",  W'(bus.comp_data_row_o), W'(mon_e.r));
        chk("done_col",  W'(bus.comp_data_col_o), W'(mon_e.c));
        chk("done_cycle", W'(cyc), W'(mon_e.cy));
      end
    end
  end

  task automatic run_search(input bit am, input int vmode, input bit mid_init, input bit rst_drain);
    int   guard;
    int   r;
    int   last_cy;
    bit   v;
    bit   acc;
    exp_t e;
    guard = 0;
    while (bus.comp_busy_o && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    chk("idle_before_init", W'(bus.comp_busy_o), W'(0));
    e = model(am);
    bus.comp_init_i = 1'b1;
    bus.comp_abs_i  = am;
    @(posedge clk); #1;
    bus.comp_init_i = 1'b0;
    r = 0; guard = 0; last_cy = 0;
    while (r < R && guard < 200) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (guard % 2) == 0;
        default: v = ($urandom % 3) != 0;
      endcase
      bus.comp_valid_i = v;
      for (int l = 0; l < N; l++)
        bus.comp_data_i[l] = v ? bd[r][l] : {$urandom, $urandom};
      bus.comp_data_mask_i = v ? bm[r] : 8'($urandom);
      bus.comp_init_i = mid_init && (r == 1);
      bus.comp_abs_i  = 1'($urandom);
      acc = v && bus.comp_ready_o;
      @(posedge clk); #1;
      if (acc) begin
        last_cy = cyc;
        r++;
      end
      guard++;
    end
    bus.comp_valid_i = 1'b0;
    bus.comp_init_i  = 1'b0;
    chk("beats_accepted", W'(r), W'(R));
    if (rst_drain) begin
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", W'(bus.comp_ready_o), W'(0));
      chk("rst_busy",  W'(bus.comp_busy_o),  W'(0));
      chk("rst_done",  W'(bus.comp_done_o),  W'(0));
      chk("rst_data",  bus.comp_data_o,      W'(0));
      chk("rst_row",   W'(bus.comp_data_row_o), W'(0));
      chk("rst_col",   W'(bus.comp_data_col_o), W'(0));
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
    end else begin
      e.cy = last_cy + S + 1;
      sbq.push_back(e);
      pushed++;
      guard = 0;
      while (bus.comp_busy_o && guard < 100) begin
        @(posedge clk); #1; guard++;
      end
      chk("search_finished", W'(bus.comp_busy_o), W'(0));
      repeat (2) @(posedge clk);
      #1;
      chk("hold_data", bus.comp_data_o, e.d);
      chk("hold_row",  W'(bus.comp_data_row_o), W'(e.r));
      chk("hold_col",  W'(bus.comp_data_col_o), W'(e.c));
    end
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < R; r++) begin
      bm[r] = '0;
      for (int l = 0; l < N; l++) begin
        case (kind)
          0:       bd[r][l] = '0;
          1:       bd[r][l] = W'(longint'(int'($urandom_range(0, 198)) - 99));
          2:       bd[r][l] = W'(longint'(int'($urandom_range(0, 16)) - 8));
          default: bd[r][l] = {$urandom, $urandom};
        endcase
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.comp_init_i = 1'b0;
    bus.comp_abs_i = 1'b0;
    bus.comp_valid_i = 1'b0;
    bus.comp_data_i = '0;
    bus.comp_data_mask_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", W'(bus.comp_ready_o), W'(0));
    chk("reset_busy",  W'(bus.comp_busy_o),  W'(0));
    chk("reset_done",  W'(bus.comp_done_o),  W'(0));
    chk("reset_data",  bus.comp_data_o,      W'(0));
    chk("reset_row",   W'(bus.comp_data_row_o), W'(0));
    chk("reset_col",   W'(bus.comp_data_col_o), W'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // magnitude winner: -100 at beat 2 lane 5
    fill(1);
    bd[2][5] = W'(longint'(-100));
    run_search(1'b1, 0, 1'b0, 1'b0);

    // ties resolve to earliest beat, then lowest lane
    fill(0);
    bd[1][3] = 64'd7; bd[1][6] = 64'd7; bd[3][3] = 64'd7; bd[3][6] = 64'd7;
    run_search(1'b1, 0, 1'b0, 1'b0);
    run_search(1'b0, 2, 1'b0, 1'b0);

    // most negative value beats everything in magnitude mode
    for (int r = 0; r < R; r++) begin
      bm[r] = '0;
      for (int l = 0; l < N; l++) bd[r][l] = 64'h7fff_ffff_ffff_ffff;
    end
    bd[0][0] = 64'h8000_0000_0000_0000;
    run_search(1'b1, 0, 1'b0, 1'b0);

    // signed mode, all negative, masked positive lane
    for (int r = 0; r < R; r++) begin
      bm[r] = '0;
      for (int l = 0; l < N; l++) bd[r][l] = W'(longint'(-int'($urandom_range(4, 1000))));
    end
    bd[3][1] = W'(longint'(-3));
    bd[0][0] = 64'd50;
    bm[0] = 8'h01;
    run_search(1'b0, 0, 1'b0, 1'b0);

    // alternating valid with an ignored init pulse mid-search
    fill(1);
    run_search(1'b1, 1, 1'b1, 1'b0);

    // fully masked beat and fully masked search in both modes
    fill(3);
    bm[0] = 8'hff;
    run_search(1'b0, 0, 1'b0, 1'b0);
    for (int r = 0; r < R; r++) bm[r] = 8'hff;
    run_search(1'b1, 0, 1'b0, 1'b0);
    run_search(1'b0, 2, 1'b0, 1'b0);

    // reset during drain, then a clean search
    fill(3);
    run_search(1'b1, 0, 1'b0, 1'b1);
    fill(1);
    run_search(1'b1, 2, 1'b0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      fill(($urandom % 2) ? 2 : 3);
      for (int r = 0; r < R; r++) bm[r] = ($urandom % 4 == 0) ? 8'($urandom) : 8'h00;
      run_search(1'($urandom), 2, 1'($urandom % 4 == 0), 1'b0);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_empty", W'(sbq.size()), W'(0));
    chk("done_count", W'(dones), W'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
